// File: rtl/uart_line_assembler.sv
// uart_line_assembler
//   Collects bytes from a UART RX strobe into a line buffer and, on each
//   CR LF terminator, streams the completed line (terminator stripped) to a
//   downstream consumer over a valid/ready byte interface. Lines that do not
//   fit in the buffer are discarded and flagged once their terminator arrives.
//
// Ports
//   i_clk         system clock, rising edge
//   i_reset       synchronous active-high reset
//   i_data_latch  one-cycle strobe, i_data holds a received byte
//   i_data        received byte
//   o_data        stream byte to consumer
//   o_valid       o_data valid
//   i_ready       consumer accepts o_data when o_valid is high
//   o_last        high with the final byte of a line
//   o_line_len    length of the line being drained (CR LF excluded)
//   o_busy        high while draining; incoming bytes are dropped
//   o_overflow    one-cycle pulse when an oversized line is discarded
//   o_dropped     one-cycle pulse per byte latched while draining
//
// State table
//   state    | meaning
//   COLLECT  | storing received bytes, watching for CR LF
//   DRAIN    | streaming the stored line out, input bytes dropped
//   OVERFLOW | line too long, discarding bytes until CR LF

module uart_line_assembler #(
    parameter int         DEPTH    = 64,
    parameter logic [7:0] CARRIAGE = 8'h0D,
    parameter logic [7:0] LINEFEED = 8'h0A,
    localparam int        LW       = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_data_latch,
    input  logic [7:0]    i_data,
    output logic [7:0]    o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_last,
    output logic [LW-1:0] o_line_len,
    output logic          o_busy,
    output logic          o_overflow,
    output logic          o_dropped
);

    localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] ONE  = LW'(1);
    localparam logic [LW-1:0] TWO  = LW'(2);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DRAIN    = 2'd1,
        OVERFLOW = 2'd2
    } state_t;

    state_t        state;
    logic [7:0]    line_buf [DEPTH];
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic          prev_cr;

    logic is_term;
    logic store;

    // prev_cr is only meaningful in COLLECT/OVERFLOW; it is cleared at every
    // line start so a CR from a previous line can never pair with a new LF.
    assign is_term = i_data_latch && (i_data == LINEFEED) && prev_cr;
    assign store   = (state == COLLECT) && i_data_latch && !is_term && (wr_ptr != FULL);

    // Storage has no reset: pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (store) begin
            line_buf[wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= COLLECT;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            prev_cr    <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_line_len <= '0;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
            o_dropped  <= 1'b0;
        end else begin
            o_overflow <= 1'b0;
            o_dropped  <= 1'b0;
            case (state)
                COLLECT: begin
                    if (i_data_latch) begin
                        if (is_term) begin
                            prev_cr <= 1'b0;
                            // wr_ptr counts the stored CR, so wr_ptr > 1 means
                            // at least one data byte precedes the terminator.
                            if (wr_ptr > ONE) begin
                                state      <= DRAIN;
                                o_line_len <= wr_ptr - ONE;
                                o_data     <= line_buf[0];
                                o_last     <= (wr_ptr == TWO);
                                o_valid    <= 1'b1;
                                o_busy     <= 1'b1;
                                rd_ptr     <= ONE;
                            end else begin
                                wr_ptr <= '0;
                            end
                        end else if (wr_ptr == FULL) begin
                            state   <= OVERFLOW;
                            prev_cr <= (i_data == CARRIAGE);
                        end else begin
                            wr_ptr  <= wr_ptr + ONE;
                            prev_cr <= (i_data == CARRIAGE);
                        end
                    end
                end

                OVERFLOW: begin
                    if (i_data_latch) begin
                        if (is_term) begin
                            o_overflow <= 1'b1;
                            wr_ptr     <= '0;
                            prev_cr    <= 1'b0;
                            state      <= COLLECT;
                        end else begin
                            prev_cr <= (i_data == CARRIAGE);
                        end
                    end
                end

                DRAIN: begin
                    o_dropped <= i_data_latch;
                    // o_valid is held high for the whole of DRAIN, so i_ready
                    // alone marks a transfer. rd_ptr always points at the byte
                    // to present after the current one (prefetch).
                    if (i_ready) begin
                        if (o_last) begin
                            state   <= COLLECT;
                            o_valid <= 1'b0;
                            o_busy  <= 1'b0;
                            o_last  <= 1'b0;
                            wr_ptr  <= '0;
                            rd_ptr  <= '0;
                        end else begin
                            o_data <= line_buf[rd_ptr[AW-1:0]];
                            o_last <= (rd_ptr == o_line_len - ONE);
                            rd_ptr <= rd_ptr + ONE;
                        end
                    end
                end

                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule
